// File: rtl/ga_host_ctrl.sv
// ga_host_ctrl: host-side initiator for one GA run; resets and seeds the GA, waits for
// finished or timeout, then streams a 6-byte result packet over a valid/ready byte link.
module ga_host_ctrl #(
    parameter int         RESET_CYCLES = 4,
    parameter int         TIMEOUT      = 1_000_000,
    parameter int         TIMEOUT_W    = 24,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] seed_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] ga_seed,
    output logic        ga_reset,
    input  logic [7:0]  ga_best,
    input  logic [26:0] ga_best_fit,
    input  logic        ga_finished,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    typedef enum logic [1:0] {IDLE, RST, RUN, SEND} state_t;

    state_t               r_state, w_next;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [2:0]           r_idx;
    logic [7:0]           r_best;
    logic [26:0]          r_fit;
    logic                 r_tmo;
    logic                 r_done;
    logic [31:0]          r_seed;
    logic                 w_xfer, w_last, w_rst_end, w_tmo_end;

    assign w_xfer    = r_state == SEND && tx_ready;
    assign w_last    = w_xfer && r_idx == 3'd5;
    assign w_rst_end = r_cnt == TIMEOUT_W'(RESET_CYCLES - 1);
    assign w_tmo_end = r_cnt == TIMEOUT_W'(TIMEOUT - 1);
    assign ga_seed   = r_seed;
    assign done      = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RST : IDLE;
            RST:     w_next = w_rst_end ? RUN : RST;
            RUN:     w_next = (ga_finished || w_tmo_end) ? SEND : RUN;
            SEND:    w_next = w_last ? IDLE : SEND;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = r_state != IDLE;
        ga_reset = r_state == IDLE || r_state == RST;
        tx_valid = r_state == SEND;
        tx_data  = !tx_valid     ? 8'h00 :
                   r_idx == 3'd0 ? HEADER :
                   r_idx == 3'd1 ? r_best :
                   r_idx == 3'd2 ? {r_tmo, 4'b0, r_fit[26:24]} :
                   r_idx == 3'd3 ? r_fit[23:16] :
                   r_idx == 3'd4 ? r_fit[15:8] : r_fit[7:0];
    end

    // One counter serves both the reset hold and the run timeout; it restarts at 0 on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seed <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_best <= '0;
            r_fit  <= '0;
            r_tmo  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (r_state == IDLE && start) r_seed <= seed_in;
            r_cnt <= (r_state != IDLE && w_next == r_state) ? r_cnt + 1'b1 : '0;
            if (r_state == RUN && w_next == SEND) begin
                r_best <= ga_best;
                r_fit  <= ga_best_fit;
                r_tmo  <= !ga_finished;
            end
            r_idx  <= (r_state != SEND || w_last) ? 3'd0 : w_xfer ? r_idx + 3'd1 : r_idx;
            r_done <= w_last;
        end
    end
endmodule
